seg7_scan_ctrl: RTL and testbench

//  Memory-mapped scan controller for the board's 4-digit 7-segment display.
//  The CPU writes a 16-bit hex value and a control word. The block time-multiplexes
//  the four digits onto the 12-bit digits bus {an[3:0], seg[7:0]} (all active-low).
//  It runs in the PLL output clock domain, between the CPU store path and the top-level pins.

---
 rtl/seg7_scan_ctrl_if.sv | 25 ++
 rtl/seg7_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Write bus and display outputs of the 7-segment scan controller.
// The CPU store path is the master; the scan controller is the slave.
interface seg7_scan_ctrl_if;
  logic        wr_en;
  logic        wr_addr;
  logic [31:0] wr_data;
  logic [11:0] digits;
  logic        frame_done;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  digits,
    input  frame_done
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output digits,
    output frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a 4-digit active-low 7-segment display.
// Live VALUE/CTRL registers are written by the CPU; the display path reads only shadow
// copies that are refreshed at the frame boundary, so a frame never shows a torn update.
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input logic             clk,
  input logic             reset,
  seg7_scan_ctrl_if.slave bus
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(SCAN_DIV - 2);
  localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYCLES);

  localparam logic [8:0] CTRL_RESET = 9'h001;

  logic [15:0]   value_q;
  logic [8:0]    ctrl_q;
  logic [15:0]   shadow_value_q;
  logic [8:0]    shadow_ctrl_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [11:0]   digits_q;
  logic          frame_done_q;

  logic          frame_end;
  logic [3:0]    nibble;
  logic          shadow_en;
  logic [3:0]    shadow_blank;
  logic [3:0]    shadow_dp;
  logic [3:0]    an_d;
  logic [7:0]    seg_d;

  // Bits above the widest register field carry no meaning.
  logic unused_wr_data;
  assign unused_wr_data = ^bus.wr_data[31:16];

  // Last cycle of digit slot 3: shadow load point and frame boundary.
  assign frame_end = (cnt_q == CNT_MAX) && (idx_q == 2'd3);

  // Hex digit to active-low gfedcba pattern.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Live registers: CPU writes land here and are not yet visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= 16'h0000;
      ctrl_q  <= CTRL_RESET;
    end else if (bus.wr_en) begin
      if (bus.wr_addr) begin
        ctrl_q <= bus.wr_data[8:0];
      end else begin
        value_q <= bus.wr_data[15:0];
      end
    end
  end

  // Shadow registers: sample the pre-write live values once per frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_value_q <= 16'h0000;
      shadow_ctrl_q  <= CTRL_RESET;
    end else if (frame_end) begin
      shadow_value_q <= value_q;
      shadow_ctrl_q  <= ctrl_q;
    end
  end

  // Slot counter and digit index; free-running regardless of enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered frame pulse, set one cycle ahead so it coincides with frame_end.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (cnt_q == CNT_PRE) && (idx_q == 2'd3);
    end
  end

  // Select the current digit's shadow fields and build the next pin pattern.
  always_comb begin
    nibble       = 4'h0;
    shadow_en    = shadow_ctrl_q[0];
    shadow_blank = shadow_ctrl_q[4:1];
    shadow_dp    = shadow_ctrl_q[8:5];
    unique case (idx_q)
      2'd0: nibble = shadow_value_q[3:0];
      2'd1: nibble = shadow_value_q[7:4];
      2'd2: nibble = shadow_value_q[11:8];
      2'd3: nibble = shadow_value_q[15:12];
    endcase

    an_d = 4'b1111;
    if (!(cnt_q < DEAD_END) && shadow_en && !shadow_blank[idx_q]) begin
      an_d = ~(4'b0001 << idx_q);
    end
    // Segments are always driven; only the anodes gate visibility.
    seg_d = {~shadow_dp[idx_q], hex7(nibble)};
  end

  // Output register for the pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q <= 12'hFFF;
    end else begin
      digits_q <= {an_d, seg_d};
    end
  end

  assign bus.digits     = digits_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=4, DEAD_CYCLES=1 (16-cycle frames).
module tb_seg7_scan_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   frame_no;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(
    .SCAN_DIV   (4),
    .DEAD_CYCLES(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-decoded segment patterns, gfedcba active-low.
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Second frame after VALUE=1234, CTRL=001: dead cycle then active cycles per slot.
  logic [11:0] exp_frame2 [16] = '{12'hF99, 12'hE99, 12'hE99, 12'hE99,
                                   12'hFB0, 12'hDB0, 12'hDB0, 12'hDB0,
                                   12'hFA4, 12'hBA4, 12'hBA4, 12'hBA4,
                                   12'hFF9, 12'h7F9, 12'h7F9, 12'h7F9};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write(input logic addr, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Runs one frame from state cnt=0,idx=0, checking each registered slot output and the
  // frame pulse; optionally issues one write during frame cycle wr_at.
  task automatic check_frame(input logic [15:0] val, input logic [8:0] ctrl, input bit do_wr,
                             input int wr_at, input logic wa, input logic [31:0] wd);
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [3:0]  nib;
    int          s;
    int          c;
    frame_no++;
    for (int i = 0; i < 16; i++) begin
      s = i / 4;
      c = i % 4;
      if (do_wr && i == wr_at) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = wa;
        bus.wr_data = wd;
      end
      tick();
      bus.wr_en = 1'b0;
      nib = val[s*4 +: 4];
      seg = {~ctrl[5 + s], hex_tab[nib]};
      an  = 4'hF;
      if (c != 0 && ctrl[0] && !ctrl[1 + s]) an = ~(4'b0001 << s);
      chk($sformatf("f%0d_digits_c%0d", frame_no, i), bus.digits, {an, seg});
      chk($sformatf("f%0d_fdone_c%0d", frame_no, i), {11'd0, bus.frame_done},
          {11'd0, (i == 14)});
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    frame_no    = 2;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 1'b0;
    bus.wr_data = 32'd0;

    // Reset for two cycles, then the cycle after release.
    tick();
    chk("rst1_digits", bus.digits, 12'hFFF);
    chk("rst1_fdone", {11'd0, bus.frame_done}, 12'd0);
    tick();
    chk("rst2_digits", bus.digits, 12'hFFF);
    reset = 1'b0;
    chk("rel_digits", bus.digits, 12'hFFF);
    chk("rel_fdone", {11'd0, bus.frame_done}, 12'd0);

    // Frame 1 shows reset shadow (0, enabled); VALUE=1234 written in cycle 0.
    write(1'b0, 32'hABCD_1234);
    chk("f1_c0_digits", bus.digits, 12'hFC0);
    for (int i = 1; i < 15; i++) begin
      chk($sformatf("f1_fdone_c%0d", i), {11'd0, bus.frame_done}, 12'd0);
      tick();
    end
    chk("f1_fdone_c15", {11'd0, bus.frame_done}, 12'd1);
    tick();
    chk("f1_last_digits", bus.digits, 12'h7C0);
    chk("f2_c0_fdone", {11'd0, bus.frame_done}, 12'd0);

    // Frame 2: 1234 displayed.
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("f2_digits_c%0d", i), bus.digits, exp_frame2[i]);
    end

    // Frame 3: mid-frame VALUE write while idx=1 stays invisible this frame.
    check_frame(16'h1234, 9'h001, 1'b1, 5, 1'b0, 32'h0000_8888);
    // Frame 4: 8888; CTRL=025 written.
    check_frame(16'h8888, 9'h001, 1'b1, 2, 1'b1, 32'h0000_0025);
    // Frame 5: digit 1 blanked, dp on digit 0; CTRL=0 written.
    check_frame(16'h8888, 9'h025, 1'b1, 2, 1'b1, 32'h0000_0000);
    // Frame 6: disabled; write coincides with frame_done cycle.
    check_frame(16'h8888, 9'h000, 1'b1, 15, 1'b1, 32'h0000_01E1);
    // Frame 7: coinciding write not yet visible.
    check_frame(16'h8888, 9'h000, 1'b0, 0, 1'b0, 32'h0);
    // Frame 8: enabled with all dp lit.
    check_frame(16'h8888, 9'h1E1, 1'b0, 0, 1'b0, 32'h0);

    // Reset mid-slot (cnt=2, idx=1).
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1;
    tick();
    chk("midrst_digits", bus.digits, 12'hFFF);
    chk("midrst_fdone", {11'd0, bus.frame_done}, 12'd0);
    reset = 1'b0;
    // Fresh frame from reset values with counters restarted.
    check_frame(16'h0000, 9'h001, 1'b0, 0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
